// File: rtl/conv_sched_pkg.sv
// Shared types for the conv -> relu -> pool pixel-unit sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, result tag carried down the delay line, default conv latency.
package conv_sched_pkg;

   localparam int CONV_LAT_DEF = 3;
   localparam int TAG_FIELD_W  = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   // Identifies which window result the unit is producing.
   typedef struct packed {
      logic                   valid;
      logic [TAG_FIELD_W-1:0] row;
      logic [TAG_FIELD_W-1:0] col;
   } tag_t;

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth shift register used to align result tags with the pixel unit output.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; shifts every cycle.
// Ports: clk, rst (sync active-low), d (WIDTH in), q (WIDTH out).
module sched_delay_line #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/conv_unit_sched.sv
// Scans an image in 3-row bands, issuing one 3-pixel column per cycle to the conv/relu/pool unit.
// Latency: first read the cycle after start; results tagged 1+CONV_LAT cycles after the window-completing read.
// Backpressure: hold freezes column reads during RUN; in-flight tags and DRAIN keep moving.
// Ports: clk, rst (sync active-low), start/hold in; busy/done status; rd_en/rd_addr0..2 to the
//        3-port pixel RAM, rd_data back; col_pix/conv_en/col_first/pool_phase to the unit;
//        out_valid/pool_valid/out_row/out_col tag the unit output.
module conv_unit_sched
   import conv_sched_pkg::*;
#(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int PIX_W    = 16,
   parameter int ADDR_W   = TAG_FIELD_W,
   parameter int CONV_LAT = CONV_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                hold,
   output logic                busy,
   output logic                done,
   output logic                rd_en,
   output logic [ADDR_W-1:0]   rd_addr0,
   output logic [ADDR_W-1:0]   rd_addr1,
   output logic [ADDR_W-1:0]   rd_addr2,
   input  logic [3*PIX_W-1:0]  rd_data,
   output logic [3*PIX_W-1:0]  col_pix,
   output logic                conv_en,
   output logic                col_first,
   output logic                pool_phase,
   output logic                out_valid,
   output logic                pool_valid,
   output logic [ADDR_W-1:0]   out_row,
   output logic [ADDR_W-1:0]   out_col
);

   localparam int                DCNT_W = $clog2(CONV_LAT + 1) + 1;
   localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(IMG_H - 3);
   localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(CONV_LAT);

   sched_state_t      state, state_nxt;
   logic [ADDR_W-1:0] col_cnt;
   logic [ADDR_W-1:0] band_cnt;
   logic [DCNT_W-1:0] drain_cnt;
   tag_t              tag_in, tag_out;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (!hold && col_cnt == C_LAST) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == D_LAST) state_nxt = (band_cnt == R_LAST) ? DONE : RUN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      rd_en = (state == RUN) && !hold;
      busy  = (state != IDLE);
      done  = (state == DONE);
   end

   // Column/band counters and row addresses. Each read advances all three addresses by one;
   // after the last column of a band the +1 already lands on the next band's first pixel,
   // so no separate wrap correction is needed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_cnt   <= '0;
         band_cnt  <= '0;
         drain_cnt <= '0;
         rd_addr0  <= '0;
         rd_addr1  <= '0;
         rd_addr2  <= '0;
      end else begin
         if (state == IDLE && start) begin
            col_cnt  <= '0;
            band_cnt <= '0;
            rd_addr0 <= '0;
            rd_addr1 <= ADDR_W'(IMG_W);
            rd_addr2 <= ADDR_W'(2 * IMG_W);
         end
         if (rd_en) begin
            col_cnt  <= (col_cnt == C_LAST) ? '0 : col_cnt + 1'b1;
            rd_addr0 <= rd_addr0 + 1'b1;
            rd_addr1 <= rd_addr1 + 1'b1;
            rd_addr2 <= rd_addr2 + 1'b1;
         end
         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
            if (drain_cnt == D_LAST && band_cnt != R_LAST) band_cnt <= band_cnt + 1'b1;
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // Column qualifiers follow the RAM's one-cycle read latency.
   always_ff @(posedge clk) begin
      if (!rst) begin
         conv_en   <= 1'b0;
         col_first <= 1'b0;
      end else begin
         conv_en   <= rd_en;
         col_first <= rd_en && (col_cnt == '0);
      end
   end

   assign col_pix = rd_data;

   // Columns 2.. complete a 3x3 window; invalid tags are zeroed so row/col read 0 between results.
   always_comb begin
      tag_in = '0;
      if (rd_en && col_cnt >= ADDR_W'(2)) begin
         tag_in.valid = 1'b1;
         tag_in.row   = TAG_FIELD_W'(band_cnt);
         tag_in.col   = TAG_FIELD_W'(col_cnt - ADDR_W'(2));
      end
   end

   // One stage for the RAM read plus CONV_LAT for the unit.
   sched_delay_line #(
      .DEPTH (1 + CONV_LAT),
      .WIDTH ($bits(tag_t))
   ) u_tag_dl (
      .clk (clk),
      .rst (rst),
      .d   (tag_in),
      .q   (tag_out)
   );

   // Output column index restarts at 0 every band, so its LSB is the pooling phase.
   assign out_valid  = tag_out.valid;
   assign out_row    = ADDR_W'(tag_out.row);
   assign out_col    = ADDR_W'(tag_out.col);
   assign pool_phase = tag_out.valid & tag_out.col[0];
   assign pool_valid = out_valid & pool_phase;

endmodule

// File: tb/tb_conv_unit_sched.sv
module tb_conv_unit_sched;
   import conv_sched_pkg::*;

   localparam int PW   = 16;
   localparam int AW   = 10;
   localparam int NCYC = 48;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, hold;
   logic [3*PW-1:0] rd_data6, rd_data7;

   logic busy6, done6, rd_en6, conv_en6, col_first6, pool_phase6, out_valid6, pool_valid6;
   logic [AW-1:0] a0_6, a1_6, a2_6, row6, col6;
   logic [3*PW-1:0] pix6;
   logic busy7, done7, rd_en7, conv_en7, col_first7, pool_phase7, out_valid7, pool_valid7;
   logic [AW-1:0] a0_7, a1_7, a2_7, row7, col7;
   logic [3*PW-1:0] pix7;

   conv_unit_sched #(.IMG_W(6), .IMG_H(5), .PIX_W(PW), .ADDR_W(AW), .CONV_LAT(3)) dut6 (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy6), .done(done6),
      .rd_en(rd_en6), .rd_addr0(a0_6), .rd_addr1(a1_6), .rd_addr2(a2_6), .rd_data(rd_data6),
      .col_pix(pix6), .conv_en(conv_en6), .col_first(col_first6), .pool_phase(pool_phase6),
      .out_valid(out_valid6), .pool_valid(pool_valid6), .out_row(row6), .out_col(col6));

   conv_unit_sched #(.IMG_W(7), .IMG_H(5), .PIX_W(PW), .ADDR_W(AW), .CONV_LAT(3)) dut7 (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy7), .done(done7),
      .rd_en(rd_en7), .rd_addr0(a0_7), .rd_addr1(a1_7), .rd_addr2(a2_7), .rd_data(rd_data7),
      .col_pix(pix7), .conv_en(conv_en7), .col_first(col_first7), .pool_phase(pool_phase7),
      .out_valid(out_valid7), .pool_valid(pool_valid7), .out_row(row7), .out_col(col7));

   typedef struct {
      logic            rd_en, conv_en, col_first, pool_phase, out_valid, pool_valid, busy, done;
      logic [AW-1:0]   a0, a1, a2, row, col;
      logic [3*PW-1:0] pix, rdd;
   } snap_t;

   typedef struct {
      int   cyc;
      logic rd_en;
      int   a0;
      logic conv_en, col_first, out_valid;
      int   row, col;
      logic pool_valid, busy, done;
   } cp_t;

   snap_t s6[NCYC];
   snap_t s7[NCYC];
   cp_t   tbl[$];

   int vec_cnt = 0;
   int miss_cnt = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // RAM contents: pixel at address a is a*5+3.
   function automatic logic [PW-1:0] fpix(input logic [AW-1:0] a);
      return PW'(a) * 16'd5 + 16'd3;
   endfunction

   function automatic logic [3*PW-1:0] trip(input logic [AW-1:0] t, input logic [AW-1:0] m,
                                            input logic [AW-1:0] b);
      return {fpix(b), fpix(m), fpix(t)};
   endfunction

   // Drive one frame: start at cycle 0, optional hold window and extra start pulses; log outputs.
   task automatic run_frame(input int hold_lo, input int hold_hi, input bit extra_start, input int ncyc);
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(negedge clk);
         if (cyc > 0 && s6[cyc-1].rd_en) rd_data6 = trip(s6[cyc-1].a0, s6[cyc-1].a1, s6[cyc-1].a2);
         if (cyc > 0 && s7[cyc-1].rd_en) rd_data7 = trip(s7[cyc-1].a0, s7[cyc-1].a1, s7[cyc-1].a2);
         start = (cyc == 0) || (extra_start && (cyc == 5 || cyc == 31));
         hold  = (cyc >= hold_lo && cyc <= hold_hi);
         #1;
         s6[cyc] = '{rd_en:rd_en6, conv_en:conv_en6, col_first:col_first6, pool_phase:pool_phase6,
                     out_valid:out_valid6, pool_valid:pool_valid6, busy:busy6, done:done6,
                     a0:a0_6, a1:a1_6, a2:a2_6, row:row6, col:col6, pix:pix6, rdd:rd_data6};
         s7[cyc] = '{rd_en:rd_en7, conv_en:conv_en7, col_first:col_first7, pool_phase:pool_phase7,
                     out_valid:out_valid7, pool_valid:pool_valid7, busy:busy7, done:done7,
                     a0:a0_7, a1:a1_7, a2:a2_7, row:row7, col:col7, pix:pix7, rdd:rd_data7};
      end
      @(negedge clk);
      start = 1'b0;
      hold  = 1'b0;
   endtask

   task automatic apply_tbl(input string tag);
      foreach (tbl[i]) begin
         cp_t   e;
         snap_t s;
         e = tbl[i];
         s = s6[e.cyc];
         chk1($sformatf("%s c%0d rd_en", tag, e.cyc), s.rd_en, e.rd_en);
         if (e.rd_en) chkn($sformatf("%s c%0d rd_addr0", tag, e.cyc), 32'(s.a0), e.a0);
         chk1($sformatf("%s c%0d conv_en", tag, e.cyc), s.conv_en, e.conv_en);
         chk1($sformatf("%s c%0d col_first", tag, e.cyc), s.col_first, e.col_first);
         chk1($sformatf("%s c%0d out_valid", tag, e.cyc), s.out_valid, e.out_valid);
         if (e.out_valid) begin
            chkn($sformatf("%s c%0d out_row", tag, e.cyc), 32'(s.row), e.row);
            chkn($sformatf("%s c%0d out_col", tag, e.cyc), 32'(s.col), e.col);
         end
         chk1($sformatf("%s c%0d pool_valid", tag, e.cyc), s.pool_valid, e.pool_valid);
         chk1($sformatf("%s c%0d busy", tag, e.cyc), s.busy, e.busy);
         chk1($sformatf("%s c%0d done", tag, e.cyc), s.done, e.done);
      end
   endtask

   // Whole-frame properties of the 6x5 instance.
   task automatic frame_checks6(input string tag, input int exp_done, input int ncyc);
      int n_ov = 0, n_pv = 0, n_done = 0, done_cyc = -1, n_rd = 0, n_cf = 0;
      int bad_addr = 0, bad_pix = 0, bad_pp = 0;
      int ea = 0, last_ea = 0;
      logic exp_pp;
      for (int c = 0; c < ncyc; c++) begin
         if (s6[c].pix !== s6[c].rdd) bad_pix++;
         if (c > 0 && s6[c].conv_en && s6[c].pix !== trip(AW'(last_ea), AW'(last_ea + 6), AW'(last_ea + 12)))
            bad_pix++;
         if (s6[c].rd_en) begin
            if (s6[c].a0 !== AW'(ea) || s6[c].a1 !== AW'(ea + 6) || s6[c].a2 !== AW'(ea + 12)) bad_addr++;
            last_ea = ea;
            ea++;
            n_rd++;
         end
         exp_pp = s6[c].out_valid & s6[c].col[0];
         if (s6[c].pool_phase !== exp_pp || s6[c].pool_valid !== exp_pp) bad_pp++;
         if (s6[c].out_valid) n_ov++;
         if (s6[c].pool_valid) n_pv++;
         if (s6[c].col_first) n_cf++;
         if (s6[c].done) begin
            n_done++;
            done_cyc = c;
         end
      end
      chkn({tag, " out_valid count"}, n_ov, 12);
      chkn({tag, " pool_valid count"}, n_pv, 6);
      chkn({tag, " rd_en count"}, n_rd, 18);
      chkn({tag, " col_first count"}, n_cf, 3);
      chkn({tag, " done count"}, n_done, 1);
      chkn({tag, " done cycle"}, done_cyc, exp_done);
      chkn({tag, " bad addresses"}, bad_addr, 0);
      chkn({tag, " bad col_pix"}, bad_pix, 0);
      chkn({tag, " bad pool_phase"}, bad_pp, 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; hold = 1'b0; rd_data6 = '0; rd_data7 = '0;
      repeat (3) @(negedge clk);
      #1;
      chkn("rst flags", 32'({busy6, done6, rd_en6, conv_en6, col_first6, pool_phase6, out_valid6, pool_valid6}), 0);
      chkn("rst addr0", 32'(a0_6), 0);
      chkn("rst addr1", 32'(a1_6), 0);
      chkn("rst addr2", 32'(a2_6), 0);
      chkn("rst tag", 32'({row6, col6}), 0);
      chkn("rst state", 32'(dut6.state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b1;

      // Nominal frame, with ignored start pulses at cycle 5 and at the done cycle.
      run_frame(-1, -1, 1'b1, 40);
      tbl.delete();
      tbl.push_back('{0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0,  0, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{2,  1, 1,  1, 1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{3,  1, 2,  1, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{6,  1, 5,  1, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{7,  0, 0,  1, 0, 1, 0, 0, 0, 1, 0});
      tbl.push_back('{8,  0, 0,  0, 0, 1, 0, 1, 1, 1, 0});
      tbl.push_back('{10, 0, 0,  0, 0, 1, 0, 3, 1, 1, 0});
      tbl.push_back('{11, 1, 6,  0, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{12, 1, 7,  1, 1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{17, 0, 0,  1, 0, 1, 1, 0, 0, 1, 0});
      tbl.push_back('{18, 0, 0,  0, 0, 1, 1, 1, 1, 1, 0});
      tbl.push_back('{22, 1, 13, 1, 1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{26, 1, 17, 1, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{30, 0, 0,  0, 0, 1, 2, 3, 1, 1, 0});
      tbl.push_back('{31, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{32, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{36, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
      apply_tbl("nom");
      frame_checks6("nom", 31, 40);

      // Odd-width instance ran alongside: 5 results per band, phases 0,1,0,1,0.
      begin
         int k = 0, n_pv = 0, bad = 0, done_cyc = -1;
         for (int c = 0; c < 40; c++) begin
            if (s7[c].out_valid) begin
               if (s7[c].row !== AW'(k / 5) || s7[c].col !== AW'(k % 5)) bad++;
               if (s7[c].pool_phase !== 1'((k % 5) % 2)) bad++;
               if (s7[c].pool_valid !== 1'((k % 5) % 2)) bad++;
               k++;
            end else if (s7[c].pool_phase || s7[c].pool_valid) bad++;
            if (s7[c].pool_valid) n_pv++;
            if (s7[c].done) done_cyc = c;
         end
         chkn("w7 out_valid count", k, 15);
         chkn("w7 pool_valid count", n_pv, 6);
         chkn("w7 phase/tag errors", bad, 0);
         chkn("w7 done cycle", done_cyc, 34);
      end

      // hold at cycles 3-4: reads resume at column 2, everything downstream slips two cycles.
      run_frame(3, 4, 1'b0, 40);
      tbl.delete();
      tbl.push_back('{2,  1, 1,  1, 1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{3,  0, 0,  1, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{4,  0, 0,  0, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{5,  1, 2,  0, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{6,  1, 3,  1, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{9,  0, 0,  1, 0, 1, 0, 0, 0, 1, 0});
      tbl.push_back('{12, 0, 0,  0, 0, 1, 0, 3, 1, 1, 0});
      tbl.push_back('{13, 1, 6,  0, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{32, 0, 0,  0, 0, 1, 2, 3, 1, 1, 0});
      tbl.push_back('{33, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1});
      apply_tbl("hold");
      frame_checks6("hold", 33, 40);

      // Reset mid-frame: three cycles low, outputs clear at once, no done afterwards.
      run_frame(-1, -1, 1'b0, 9);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chkn("abort flags", 32'({busy6, done6, rd_en6, conv_en6, col_first6, pool_phase6, out_valid6, pool_valid6}), 0);
      chkn("abort addr0", 32'(a0_6), 0);
      chkn("abort tag", 32'({row6, col6}), 0);
      chkn("abort state", 32'(dut6.state), 32'(IDLE));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      begin
         int n_done = 0, n_busy = 0;
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (done6) n_done++;
            if (busy6) n_busy++;
         end
         chkn("abort done pulses", n_done, 0);
         chkn("abort busy cycles", n_busy, 0);
      end

      // Clean frame after the abort starts again from (0,0).
      run_frame(-1, -1, 1'b0, 40);
      tbl.delete();
      tbl.push_back('{1,  1, 0,  0, 0, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{7,  0, 0,  1, 0, 1, 0, 0, 0, 1, 0});
      apply_tbl("restart");
      frame_checks6("restart", 31, 40);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
